spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_master_ctrl_if.sv | 16 +
 rtl/spi_shifter.sv | 40 ++++
 rtl/spi_master_ctrl.sv | 130 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared opcodes, widths and FSM state encoding for the SPI master controller.
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_END
  } state_e;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response bundle of the SPI master controller.
interface spi_master_ctrl_if;
  // Handshake: start is a one-cycle request, taken only while busy=0; busy
  // stays high until the frame ends, and done (plus rd_valid for reads)
  // pulses once, with rdata valid in that same cycle.
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rd_valid;

  modport master (output start, cmd, wdata, input busy, done, rdata, rd_valid);
  modport slave  (input start, cmd, wdata, output busy, done, rdata, rd_valid);
endinterface

// File: rtl/spi_shifter.sv
// 10-bit parallel-load MSB-first transmit register plus 8-bit serial capture.
module spi_shifter
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CMD_W-1:0]  load_data,
  input  logic              shift_en,
  input  logic              cap_en,
  input  logic              sin,
  output logic              sout,
  output logic [DATA_W-1:0] cap_data
);

  logic [CMD_W-1:0]  frame_q, frame_d;
  logic [DATA_W-1:0] cap_q, cap_d;

  always_comb begin
    frame_d = frame_q;
    cap_d   = cap_q;
    if (load)          frame_d = load_data;
    else if (shift_en) frame_d = {frame_q[CMD_W-2:0], 1'b0};
    if (cap_en)        cap_d   = {cap_q[DATA_W-2:0], sin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      cap_q   <= '0;
    end else begin
      frame_q <= frame_d;
      cap_q   <= cap_d;
    end
  end

  assign sout     = frame_q[CMD_W-1];
  assign cap_data = cap_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: sends {cmd,wdata} MSB first behind a r/w bit, then for RD_DATA
// waits TURNAROUND cycles and captures one byte from MISO.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int TURNAROUND = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_ctrl_if.slave   host,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO,
  output state_e             state_o
);

  localparam logic [3:0] SHIFT_LAST = 4'(CMD_W - 1);
  localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(TURNAROUND - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              load, shift_en, cap_en, sout;
  logic              done_w, rd_valid_w;
  logic [DATA_W-1:0] cap_data;

  spi_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data ({host.cmd, host.wdata}),
    .shift_en  (shift_en),
    .cap_en    (cap_en),
    .sin       (MISO),
    .sout      (sout),
    .cap_data  (cap_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    rdata_d    = rdata_q;
    load       = 1'b0;
    shift_en   = 1'b0;
    cap_en     = 1'b0;
    SS_n       = 1'b0;
    MOSI       = 1'b0;
    done_w     = 1'b0;
    rd_valid_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        SS_n = 1'b1;
        if (host.start) begin
          cmd_d   = host.cmd;
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        MOSI    = cmd_q[1];
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        MOSI     = sout;
        shift_en = 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (cmd_q != RD_DATA)     state_d = ST_END;
          else if (TURNAROUND == 0) state_d = ST_RECV;
          else                      state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RECV: begin
        cap_en = 1'b1;
        if (cnt_q == RECV_LAST) begin
          cnt_d   = '0;
          state_d = ST_END;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_END: begin
        SS_n       = 1'b1;
        done_w     = 1'b1;
        rd_valid_w = (cmd_q == RD_DATA);
        if (cmd_q == RD_DATA) rdata_d = cap_data;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  // rdata_q only commits at the end of END, so the fresh byte is bypassed
  // straight from the capture register while rd_valid is high.
  assign host.rdata    = rd_valid_w ? cap_data : rdata_q;
  assign host.busy     = (state_q != ST_IDLE);
  assign host.done     = done_w;
  assign host.rd_valid = rd_valid_w;
  assign state_o       = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with an SPI slave + RAM model on the pins.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int TA = 2;
  localparam int W  = 17;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   SS_n, MOSI;
  logic   MISO = 1'b0;
  state_e state_o;

  spi_master_ctrl_if bus ();

  spi_master_ctrl #(.TURNAROUND(TA)) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (bus),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected frame record: {SS_n-low length, r/w bit, cmd, wdata, any MOSI=1 after bit 10}
  function automatic logic [W-1:0] exp_frame(input logic [1:0] c, input logic [7:0] d);
    int len;
    len = (c == 2'b11) ? 11 + TA + 8 : 11;
    return {5'(len), c[1], c, d, 1'b0};
  endfunction

  // ---------------- slave + RAM model ----------------
  int         s_cnt = 0;
  logic [10:0] s_word = '0;
  logic       s_tail = 1'b0;
  logic [7:0] s_addr = '0;
  logic [7:0] s_rd_byte = '0;
  logic [7:0] s_mem [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt  = 0;
      s_word = '0;
      s_tail = 1'b0;
    end else if (!SS_n) begin
      if (s_cnt < 11) s_word = {s_word[9:0], MOSI};
      else            s_tail = s_tail | MOSI;
      s_cnt++;
      if (s_cnt == 11) begin
        case (s_word[9:8])
          2'b00:   s_addr = s_word[7:0];
          2'b01:   s_mem[s_addr] = s_word[7:0];
          2'b10:   s_addr = s_word[7:0];
          default: s_rd_byte = s_mem[s_addr];
        endcase
      end
    end else if (s_cnt > 0) begin
      if (exp_q.size() == 0) check("frame_unexpected", 32'(s_word), 32'h0);
      else check("frame", 32'({5'(s_cnt), s_word, s_tail}), 32'(exp_q.pop_front()));
      s_cnt  = 0;
      s_word = '0;
      s_tail = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!SS_n && s_cnt >= 11 + TA && s_cnt <= 11 + TA + 7) MISO = s_rd_byte[11 + TA + 7 - s_cnt];
    else MISO = 1'($urandom_range(0, 1));
  end

  // ---------------- monitors ----------------
  int done_cnt  = 0;
  int idle_run  = 0;
  int last_idle = 0;

  always @(posedge clk) begin
    if (bus.done) done_cnt++;
    if (state_o == ST_IDLE) idle_run++;
    else begin
      if (idle_run > 0) last_idle = idle_run;
      idle_run = 0;
    end
  end

  // ---------------- driver ----------------
  logic [7:0] got_rdata;
  logic       got_rv;

  task automatic run_frame(input logic [1:0] c, input logic [7:0] d,
                           input int ra, input int rb, output int lat);
    exp_q.push_back(exp_frame(c, d));
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = c; bus.wdata = d;
    @(negedge clk);
    bus.start = 1'b0; bus.cmd = ~c; bus.wdata = ~d;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("mosi_start_bit", 32'(MOSI), 32'(c[1]));
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      bus.start = (n == ra || n == rb);
      if (bus.done) begin
        lat       = n;
        got_rdata = bus.rdata;
        got_rv    = bus.rd_valid;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check("frame_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  int lat;
  int base;
  int seen;

  initial begin
    bus.start = 1'b0; bus.cmd = 2'b00; bus.wdata = 8'h00;
    for (int i = 0; i < 256; i++) s_mem[i] = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ss_n", 32'(SS_n), 32'd1);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'h00);
    rst = 1'b0;
    @(negedge clk);

    // WR_ADDR A5: 11-bit MOSI sequence 0,0,0,1,0,1,0,0,1,0,1
    run_frame(2'b00, 8'hA5, 0, 0, lat);
    check("wr_addr_latency", 32'(lat), 32'd12);
    check("wr_addr_rd_valid", 32'(got_rv), 32'd0);
    check("idle_mosi", 32'(MOSI), 32'd0);

    // RD_DATA with the slave returning 3C
    s_mem[s_addr] = 8'h3C;
    run_frame(2'b11, 8'h00, 0, 0, lat);
    check("rd_data_latency", 32'(lat), 32'(12 + TA + 8));
    check("rd_data_rd_valid", 32'(got_rv), 32'd1);
    check("rd_data_rdata", 32'(got_rdata), 32'h3C);

    // start re-pulsed inside the frame and during END is ignored
    base = done_cnt;
    run_frame(2'b10, 8'h42, 3, 12, lat);
    check("repulse_latency", 32'(lat), 32'd12);
    repeat (20) @(negedge clk);
    check("repulse_done_count", 32'(done_cnt - base), 32'd1);
    check("repulse_busy_after", 32'(bus.busy), 32'd0);

    // reset in the middle of an RD_DATA frame
    base = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 2'b11; bus.wdata = 8'h77;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ss_n", 32'(SS_n), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_state", 32'(state_o), 32'(ST_IDLE));
    check("abort_rdata", 32'(bus.rdata), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    run_frame(2'b01, 8'h96, 0, 0, lat);
    check("post_abort_latency", 32'(lat), 32'd12);

    // loopback through the slave RAM
    run_frame(2'b00, 8'h10, 0, 0, lat);
    run_frame(2'b01, 8'h5A, 0, 0, lat);
    run_frame(2'b10, 8'h10, 0, 0, lat);
    run_frame(2'b11, 8'hFF, 0, 0, lat);
    check("loopback_rdata", 32'(got_rdata), 32'h5A);
    check("loopback_latency", 32'(lat), 32'(12 + TA + 8));

    // rdata holds across non-read opcodes
    run_frame(2'b00, 8'h33, 0, 0, lat);
    check("rdata_hold", 32'(bus.rdata), 32'h5A);

    // start held high: two frames separated by a single IDLE cycle
    exp_q.push_back(exp_frame(2'b01, 8'hC3));
    exp_q.push_back(exp_frame(2'b01, 8'hC3));
    base = done_cnt;
    seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 2'b01; bus.wdata = 8'hC3;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) seen++;
      if (seen == 2) begin
        bus.start = 1'b0;
        break;
      end
    end
    check("b2b_done_seen", 32'(seen), 32'd2);
    check("b2b_idle_gap", 32'(last_idle), 32'd1);
    repeat (5) @(negedge clk);
    check("b2b_done_count", 32'(done_cnt - base), 32'd2);
    check("b2b_busy_after", 32'(bus.busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
